// File: rtl/psum_out_arbiter_pkg.sv
// ============================================================================
// Module   : psum_pkg
// Purpose  : Shared packet field offsets, default field values and FSM states
//            for the partial-sum output arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package psum_pkg;

    localparam int c_VALID_BIT = 46;
    localparam int c_DEST_LSB  = 43;
    localparam int c_SRC_LSB   = 40;
    localparam int c_FILL_LSB  = 8;

    localparam logic [2:0]  c_DEST_MEM = 3'b110;
    localparam logic [31:0] c_FILL     = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/psum_out_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot grant generator; owns the last-grant pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic [IW-1:0] r_last_q;
    logic [IW-1:0] w_last_d;
    logic [IW-1:0] w_cand;
    logic          w_found;

    // Scan starts one past the last winner so every source gets a turn.
    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int off = 1; off <= N; off++) begin
            w_cand = IW'((int'(r_last_q) + off) % N);
            if (enable && !w_found && req[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                index         = w_cand;
            end
        end
    end

    always_comb begin
        w_last_d = r_last_q;
        if (advance) begin
            w_last_d = index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_q <= IW'(N - 1);
        end else begin
            r_last_q <= w_last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/psum_out_arbiter.sv
// ============================================================================
// Module   : psum_out_arbiter
// Purpose  : Shares the memory packet port among NREQ adder streams and stops
//            after TOTAL packets per layer, signalling done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_out_arbiter
    import psum_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter int          DWIDTH   = 8,
    parameter int          PWIDTH   = 47,
    parameter int          TOTAL    = 16,
    parameter logic [2:0]  DEST_MEM = c_DEST_MEM,
    parameter logic [31:0] FILL     = c_FILL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*DWIDTH-1:0]       req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         out_valid,
    output logic [PWIDTH-1:0]            out_packet,
    input  logic                         out_ready,
    output logic                         done,
    output logic [$clog2(TOTAL+1)-1:0]   count
);

    localparam int              c_CW    = $clog2(TOTAL + 1);
    localparam int              c_IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_CW-1:0] c_TOTAL = c_CW'(TOTAL);

    if (PWIDTH != 39 + DWIDTH) begin : g_bad_pwidth
        $error("psum_out_arbiter: PWIDTH must equal 39+DWIDTH");
    end
    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("psum_out_arbiter: NREQ must be in 1..8");
    end
    if (TOTAL < 1) begin : g_bad_total
        $error("psum_out_arbiter: TOTAL must be at least 1");
    end

    state_t              r_state_q, w_state_d;
    logic [c_CW-1:0]     r_acc_q, w_acc_d;
    logic [c_CW-1:0]     r_dlv_q, w_dlv_d;
    logic                r_valid_q, w_valid_d;
    logic [PWIDTH-1:0]   r_pkt_q, w_pkt_d;

    logic [NREQ-1:0]     w_grant;
    logic [c_IW-1:0]     w_index;
    logic                w_slot_free;
    logic                w_enable;
    logic                w_src_hs;
    logic                w_out_hs;
    logic [DWIDTH-1:0]   w_psum;
    logic [PWIDTH-1:0]   w_pkt_new;

    assign w_slot_free = !r_valid_q || out_ready;
    assign w_enable    = (r_state_q == RUN) && w_slot_free && (r_acc_q != c_TOTAL);
    assign w_src_hs    = |w_grant;
    assign w_out_hs    = r_valid_q && out_ready;
    assign w_psum      = req_data[int'(w_index)*DWIDTH +: DWIDTH];
    assign w_pkt_new   = {1'b1, DEST_MEM, 3'(w_index), FILL, w_psum};

    rr_arbiter #(
        .N  (NREQ),
        .IW (c_IW)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .enable  (w_enable),
        .advance (w_src_hs),
        .grant   (w_grant),
        .index   (w_index)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_dlv_d   = r_dlv_q;
        w_valid_d = r_valid_q;
        w_pkt_d   = r_pkt_q;

        // A new capture and a delivery in the same cycle keep the slot full.
        if (w_src_hs) begin
            w_valid_d = 1'b1;
            w_pkt_d   = w_pkt_new;
        end else if (w_out_hs) begin
            w_valid_d = 1'b0;
        end

        unique case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_state_d = RUN;
                    w_acc_d   = '0;
                    w_dlv_d   = '0;
                end
            end
            RUN: begin
                if (w_src_hs && (r_acc_q != c_TOTAL)) begin
                    w_acc_d = r_acc_q + c_CW'(1);
                end
                if (w_out_hs && (r_dlv_q != c_TOTAL)) begin
                    w_dlv_d = r_dlv_q + c_CW'(1);
                end
                if (w_dlv_d == c_TOTAL) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_d = RUN;
                    w_acc_d   = '0;
                    w_dlv_d   = '0;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_acc_q   <= '0;
            r_dlv_q   <= '0;
            r_valid_q <= 1'b0;
            r_pkt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_dlv_q   <= w_dlv_d;
            r_valid_q <= w_valid_d;
            r_pkt_q   <= w_pkt_d;
        end
    end

    assign req_ready  = w_grant;
    assign out_valid  = r_valid_q;
    assign out_packet = r_pkt_q;
    assign done       = (r_state_q == DONE);
    assign count      = r_dlv_q;

endmodule

`default_nettype wire

// File: tb/tb_psum_out_arbiter.sv
// ============================================================================
// Module   : tb_psum_out_arbiter
// Purpose  : Directed self-checking bench for psum_out_arbiter (NREQ=4, TOTAL=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_out_arbiter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [46:0] out_packet;
    logic        out_ready;
    logic        done;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    int         e;
    logic [3:0] oh;

    psum_out_arbiter #(
        .NREQ   (4),
        .DWIDTH (8),
        .PWIDTH (47),
        .TOTAL  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_packet (out_packet),
        .out_ready  (out_ready),
        .done       (done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [46:0] pkt(input logic [2:0] src, input logic [7:0] ps);
        return {1'b1, 3'b110, src, 32'h0000_FFFF, ps};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        out_ready = 1'b0;
        #3;
        chk("rst_ready", 64'(req_ready), 64'(4'b0000));
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_packet", 64'(out_packet), 64'(47'h0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_count", 64'(count), 64'(4'd0));
        tick();
        rst = 1'b0;

        // Single source 2, back-to-back with out_ready held high.
        req_valid = 4'b0100;
        req_data  = 32'h0005_0000;
        out_ready = 1'b1;
        start     = 1'b1;
        #1 chk("t1_start_cycle_ready", 64'(req_ready), 64'(4'b0000));
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_data = 32'h0;
            req_data[23:16] = 8'(8'h05 + k);
            #1 chk("t1_ready", 64'(req_ready), 64'(4'b0100));
            tick();
            chk("t1_valid", 64'(out_valid), 64'(1'b1));
            chk("t1_packet", 64'(out_packet), 64'(pkt(3'd2, 8'(8'h05 + k))));
            chk("t1_count", 64'(count), 64'(k));
        end
        chk("t1_no_more_grant", 64'(req_ready), 64'(4'b0000));
        chk("t1_done_before_last", 64'(done), 64'(1'b0));
        tick();
        chk("t1_done", 64'(done), 64'(1'b1));
        chk("t1_final_count", 64'(count), 64'(4'd8));
        chk("t1_valid_cleared", 64'(out_valid), 64'(1'b0));

        // Re-arm from DONE with all sources valid; pointer last granted 2.
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        start     = 1'b1;
        #1 chk("t2_done_start_ready", 64'(req_ready), 64'(4'b0000));
        tick();
        start = 1'b0;
        chk("t2_done_cleared", 64'(done), 64'(1'b0));
        chk("t2_count_cleared", 64'(count), 64'(4'd0));
        for (int k = 0; k < 8; k++) begin
            e  = (3 + k) % 4;
            oh = 4'b0001 << e;
            start = (k == 3);
            #1 chk("t2_grant", 64'(req_ready), 64'(oh));
            tick();
            start = 1'b0;
            chk("t2_packet", 64'(out_packet), 64'(pkt(3'(e), 8'(8'h10 + e))));
            chk("t2_count", 64'(count), 64'(k));
        end
        chk("t2_no_ninth", 64'(req_ready), 64'(4'b0000));
        tick();
        chk("t2_done", 64'(done), 64'(1'b1));
        chk("t2_final_count", 64'(count), 64'(4'd8));

        // Back-pressure: pointer last granted 2, so source 3 goes first.
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        #1 chk("bp_first_grant", 64'(req_ready), 64'(4'b1000));
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready_low", 64'(req_ready), 64'(4'b0000));
            chk("bp_packet_held", 64'(out_packet), 64'(pkt(3'd3, 8'h13)));
            chk("bp_valid_held", 64'(out_valid), 64'(1'b1));
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_grant", 64'(req_ready), 64'(4'b0001));
        tick();
        chk("bp_count1", 64'(count), 64'(4'd1));
        chk("bp_next_packet", 64'(out_packet), 64'(pkt(3'd0, 8'h10)));
        #1 chk("bp_grant1", 64'(req_ready), 64'(4'b0010));
        tick();
        #1 chk("bp_grant2", 64'(req_ready), 64'(4'b0100));
        tick();
        chk("bp_count3", 64'(count), 64'(4'd3));
        chk("bp_valid_pending", 64'(out_valid), 64'(1'b1));

        // Reset mid-layer, checked before any further clock edge.
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(1'b0));
        chk("ar_packet", 64'(out_packet), 64'(47'h0));
        chk("ar_count", 64'(count), 64'(4'd0));
        chk("ar_done", 64'(done), 64'(1'b0));
        chk("ar_ready", 64'(req_ready), 64'(4'b0000));
        tick();
        rst = 1'b0;

        // Fresh layer after reset: source 0 first, strict rotation.
        start = 1'b1;
        #1 chk("t3_start_cycle_ready", 64'(req_ready), 64'(4'b0000));
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e  = k % 4;
            oh = 4'b0001 << e;
            #1 chk("t3_grant", 64'(req_ready), 64'(oh));
            tick();
            chk("t3_packet", 64'(out_packet), 64'(pkt(3'(e), 8'(8'h10 + e))));
            chk("t3_count", 64'(count), 64'(k));
        end
        chk("t3_no_ninth", 64'(req_ready), 64'(4'b0000));
        tick();
        chk("t3_done", 64'(done), 64'(1'b1));
        chk("t3_final_count", 64'(count), 64'(4'd8));
        tick();
        chk("t3_idle_ready", 64'(req_ready), 64'(4'b0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psum_out_arbiter.md
# psum_out_arbiter

Clocked round-robin arbiter and sequencer for the final-output path to memory. It shares the single memory-bound packet port among `NREQ` adder result streams. Each granted partial sum is packed into the standard packet, and packets are issued one per handshake. The block stops after exactly `TOTAL` results per layer and raises `done` so the top-level controller can start the next layer.

## Interface
- `NREQ`, 4: number of adder result sources; 1..8.
- `DWIDTH`, 8: partial-sum width.
- `PWIDTH`, 47: packet width; must equal 39+`DWIDTH`. Elaboration error otherwise.
- `TOTAL`, 16: results per layer; ≥1.
- `DEST_MEM`, 3'b110: destination-address field value.
- `FILL`, 32'h0000_FFFF: value placed in the 32-bit upper data field.

Ports:
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; clears the counters and begins a layer.
- `req_valid` in `NREQ`: source i has a partial sum available.
- `req_data` in `NREQ*DWIDTH`: source i's data is in slice [i*DWIDTH +: DWIDTH].
- `req_ready` out `NREQ`: one-hot grant; source i's data is consumed when `req_valid[i]` and `req_ready[i]` are both high.
- `out_valid` out 1: `out_packet` holds a valid packet.
- `out_packet` out `PWIDTH`: packet to memory.
- `out_ready` in 1: memory side accepts the packet.
- `done` out 1: high while the layer is complete.
- `count` out $clog2(`TOTAL`+1): number of packets delivered this layer.

## Operation
- Packet layout (MSB→LSB) is {1'b1, `DEST_MEM`, src_id[2:0], `FILL`, psum}.
  - src_id is the granted index i.
  - psum is captured unmodified; no arithmetic is applied.
- States:
  - IDLE: entered on reset. No grants. `done`=0.
  - RUN: entered from IDLE on `start`.
  - DONE: entered from RUN when delivered == `TOTAL`. `done`=1. A `start` pulse clears the counters and moves to RUN.
- `start` is ignored while in RUN.
- Output register: one entry, holding `out_valid` and `out_packet`.
  - The slot is free when `out_valid`=0 or (`out_valid` && `out_ready`).
- Grant rule: in RUN, with the slot free and accepted < `TOTAL`, grant the first valid source scanning from (last_grant+1) mod `NREQ`.
  - At most one `req_ready` bit is high in any cycle.
  - `req_ready` is Mealy: combinational from `req_valid`, `out_ready` and state.
- The pointer last_grant updates only on an accepted grant. Its reset value is `NREQ`-1, so source 0 has first priority.
- Counters:
  - accepted increments on a source handshake.
  - delivered (`count`) increments on an output handshake.
  - Both saturate at `TOTAL`.
- Once accepted == `TOTAL`, all `req_ready` bits stay 0 until the next `start`.
- Back-pressure: while `out_valid`=1 and `out_ready`=0, `out_packet` is held stable and no grant is issued.
- A source may drop `req_valid` without a handshake; no state changes.

## Timing
- Reset values: `req_ready`=0, `out_valid`=0, `out_packet`=0, `done`=0, `count`=0, state=IDLE, counters=0, last_grant=`NREQ`-1.
- Reset asserted mid-layer: the in-flight packet is discarded and all state returns to the reset values immediately, without waiting for a clock edge.
- Latency: a source handshake at edge k makes `out_valid` high after edge k.
- Throughput: one packet per cycle while `out_ready` is held at 1.
- `done` rises on the edge that completes the `TOTAL`th output handshake.
- `start` in DONE: on the next edge, `done`=0, `count`=0, state=RUN. Grants may begin in that same cycle after the edge.
- `start` in IDLE: state=RUN after the edge. No grant is issued in the `start` cycle itself.
- `start` in the same cycle as the final output handshake: the layer completes; state=DONE and `start` is ignored.

## Structure
- Package `psum_pkg` holds:
  - packet field offsets: VALID_BIT=46, DEST_LSB=43, SRC_LSB=40, FILL_LSB=8;
  - `DEST_MEM`, `FILL`;
  - the state enum {IDLE, RUN, DONE}.
- Sub-module `rr_arbiter #(N)`:
  - inputs: req, enable, advance;
  - outputs: one-hot grant and index.
  - It holds the pointer; the parent handles the packet register and counters.

## Test plan
- Single source, `NREQ`=4, `TOTAL`=4: `start`, source 2 offers 8'h05, 8'h06, 8'h07, 8'h08 with `out_ready`=1.
  - Packets carry src_id 3'b010, dest 3'b110, `FILL` 32'h0000FFFF and psum 8'h05..8'h08, back-to-back.
  - `done`=1 after the 4th packet; `count`=4.
- All 4 sources always valid, `TOTAL`=8.
  - Grant order is 0,1,2,3,0,1,2,3.
  - No 9th grant; `req_ready` stays 0 after the 8th handshake.
- Back-pressure: hold `out_ready`=0 for 5 cycles with one packet pending.
  - `out_packet` is stable throughout; `req_ready` is all 0.
  - Release `out_ready`: the pending packet is delivered, then the next grant proceeds.
- Reset mid-layer: assert `rst` after 3 of 8 deliveries while `out_valid`=1.
  - Outputs go to their reset values asynchronously.
  - After `start`, `count` restarts at 0 and source 0 is granted first.
- DONE re-arm: with `done`=1, pulse `start`.
  - `done` clears and `count`=0 the next cycle.
  - A second layer of `TOTAL` packets completes normally.
- `start` pulsed in RUN mid-layer: ignored; `count` keeps progressing.
